// File: rtl/mux_32.sv
// mux_32: 32-to-1 selector with a combinational output and a registered copy.
// Input k of d sits at d[k*WIDTH +: WIDTH]; s picks which input drives y.
// y_q captures y on a rising clk edge when the load condition holds, and
// clears asynchronously while rst_n is low.
// Optional feature macro: MUX32_VALID_EN (adds in_valid / out_valid and
// gates the capture of y_q with in_valid).
module mux_32 #(
   parameter int WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [32*WIDTH-1:0]   d,
   input  logic [4:0]            s,
   input  logic                  ld,
`ifdef MUX32_VALID_EN
   input  logic                  in_valid,
   output logic                  out_valid,
`endif
   output logic [WIDTH-1:0]      y,
   output logic [WIDTH-1:0]      y_q
);

   logic load_d;

   // Route input number s to y; an unknown select poisons y with X.
   always_comb begin
      y = {WIDTH{1'bx}};
      case (s)
         5'd0:    y = d[0*WIDTH +: WIDTH];
         5'd1:    y = d[1*WIDTH +: WIDTH];
         5'd2:    y = d[2*WIDTH +: WIDTH];
         5'd3:    y = d[3*WIDTH +: WIDTH];
         5'd4:    y = d[4*WIDTH +: WIDTH];
         5'd5:    y = d[5*WIDTH +: WIDTH];
         5'd6:    y = d[6*WIDTH +: WIDTH];
         5'd7:    y = d[7*WIDTH +: WIDTH];
         5'd8:    y = d[8*WIDTH +: WIDTH];
         5'd9:    y = d[9*WIDTH +: WIDTH];
         5'd10:   y = d[10*WIDTH +: WIDTH];
         5'd11:   y = d[11*WIDTH +: WIDTH];
         5'd12:   y = d[12*WIDTH +: WIDTH];
         5'd13:   y = d[13*WIDTH +: WIDTH];
         5'd14:   y = d[14*WIDTH +: WIDTH];
         5'd15:   y = d[15*WIDTH +: WIDTH];
         5'd16:   y = d[16*WIDTH +: WIDTH];
         5'd17:   y = d[17*WIDTH +: WIDTH];
         5'd18:   y = d[18*WIDTH +: WIDTH];
         5'd19:   y = d[19*WIDTH +: WIDTH];
         5'd20:   y = d[20*WIDTH +: WIDTH];
         5'd21:   y = d[21*WIDTH +: WIDTH];
         5'd22:   y = d[22*WIDTH +: WIDTH];
         5'd23:   y = d[23*WIDTH +: WIDTH];
         5'd24:   y = d[24*WIDTH +: WIDTH];
         5'd25:   y = d[25*WIDTH +: WIDTH];
         5'd26:   y = d[26*WIDTH +: WIDTH];
         5'd27:   y = d[27*WIDTH +: WIDTH];
         5'd28:   y = d[28*WIDTH +: WIDTH];
         5'd29:   y = d[29*WIDTH +: WIDTH];
         5'd30:   y = d[30*WIDTH +: WIDTH];
         5'd31:   y = d[31*WIDTH +: WIDTH];
         default: y = {WIDTH{1'bx}};
      endcase
   end

   // Decide whether the coming edge captures y into y_q.
   always_comb begin
`ifdef MUX32_VALID_EN
      load_d = in_valid & ld;
`else
      load_d = ld;
`endif
   end

`ifdef MUX32_VALID_EN
   // Output register plus its valid flag; both clear while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q       <= {WIDTH{1'b0}};
         out_valid <= 1'b0;
      end else begin
         out_valid <= load_d;
         if (load_d) begin
            y_q <= y;
         end else begin
            y_q <= y_q;
         end
      end
   end
`else
   // Output register; captures y when loaded, clears while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= {WIDTH{1'b0}};
      end else if (load_d) begin
         y_q <= y;
      end else begin
         y_q <= y_q;
      end
   end
`endif

endmodule

// File: tb/tb_mux_32.sv
// Self-checking bench for mux_32: one WIDTH=1 and one WIDTH=8 instance share
// the select, load and reset. A behavioural model (shift-based selection and
// a captured-value variable updated at each edge) is compared every cycle,
// alongside directed checks with literal expectations.
module tb_mux_32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   d1;
   logic [255:0]  d8;
   logic [4:0]    s;
   logic          ld;
   logic          y1, y1_q;
   logic [7:0]    y8, y8_q;
`ifdef MUX32_VALID_EN
   logic          in_valid;
   logic          ov1, ov8;
   logic          exp_ov;
`endif

   int            checks = 0;
   int            failures = 0;
   logic          exp_y1_q;
   logic [7:0]    exp_y8_q;
   bit            cmp_en = 1'b0;

   always #5 clk = ~clk;

   mux_32 #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .d(d1), .s(s), .ld(ld),
`ifdef MUX32_VALID_EN
      .in_valid(in_valid), .out_valid(ov1),
`endif
      .y(y1), .y_q(y1_q)
   );

   mux_32 #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .d(d8), .s(s), .ld(ld),
`ifdef MUX32_VALID_EN
      .in_valid(in_valid), .out_valid(ov8),
`endif
      .y(y8), .y_q(y8_q)
   );

   function automatic logic pick1(logic [31:0] dv, logic [4:0] sv);
      logic [31:0] t;
      t = dv >> sv;
      return t[0];
   endfunction

   function automatic logic [7:0] pick8(logic [255:0] dv, logic [4:0] sv);
      logic [255:0] t;
      t = dv >> (int'(sv) * 8);
      return t[7:0];
   endfunction

   function automatic logic capture_now();
`ifdef MUX32_VALID_EN
      return ld & in_valid;
`else
      return ld;
`endif
   endfunction

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one rising edge and update the model from the pre-edge inputs.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         exp_y1_q = 1'b0;
         exp_y8_q = 8'h00;
`ifdef MUX32_VALID_EN
         exp_ov = 1'b0;
`endif
      end else begin
`ifdef MUX32_VALID_EN
         exp_ov = ld & in_valid;
`endif
         if (capture_now()) begin
            exp_y1_q = pick1(d1, s);
            exp_y8_q = pick8(d8, s);
         end
      end
      #1;
   endtask

   task automatic do_reset_now();
      rst_n = 1'b0;
      exp_y1_q = 1'b0;
      exp_y8_q = 8'h00;
`ifdef MUX32_VALID_EN
      exp_ov = 1'b0;
`endif
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_y1",   {7'b0, y1},   {7'b0, pick1(d1, s)});
         check("cyc_y8",   y8,           pick8(d8, s));
         check("cyc_y1_q", {7'b0, y1_q}, {7'b0, exp_y1_q});
         check("cyc_y8_q", y8_q,         exp_y8_q);
`ifdef MUX32_VALID_EN
         check("cyc_ov1",  {7'b0, ov1},  {7'b0, exp_ov});
         check("cyc_ov8",  {7'b0, ov8},  {7'b0, exp_ov});
`endif
      end
   end

   initial begin
      logic [31:0] pat;
      // Reset state, with y still live during reset.
      d1 = 32'h0;
      d8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      d8[7:0] = 8'h5A;
      s = 5'd0;
      ld = 1'b0;
`ifdef MUX32_VALID_EN
      in_valid = 1'b0;
`endif
      do_reset_now();
      #2;
      check("reset_y8_q", y8_q, 8'h00);
      check("reset_y1_q", {7'b0, y1_q}, 8'h00);
      check("reset_y8_live", y8, 8'h5A);
      ld = 1'b1;
`ifdef MUX32_VALID_EN
      in_valid = 1'b1;
`endif
      tick();
      check("reset_hold_y8_q", y8_q, 8'h00);
      rst_n = 1'b1;
      ld = 1'b0;
      cmp_en = 1'b1;

      // Walking one on the WIDTH=1 instance.
      for (int k = 0; k < 32; k++) begin
         d1 = 32'h1 << k;
         s = 5'(k);
         #1;
         check("walk_hit", {7'b0, y1}, 8'h01);
         s = 5'(k + 1);
         #1;
         check("walk_miss", {7'b0, y1}, 8'h00);
         tick();
      end

      // Exhaustive select sweep against a fixed pattern.
      pat = 32'hA5C3_0F96;
      d1 = pat;
      for (int k = 0; k < 32; k++) begin
         s = 5'(k);
         #1;
         check("sweep", {7'b0, y1}, {7'b0, pat[k]});
         tick();
      end

      // Registered path: capture 3C from input 7, then hold.
      d8[7*8 +: 8] = 8'h3C;
      s = 5'd7;
      ld = 1'b1;
`ifdef MUX32_VALID_EN
      in_valid = 1'b1;
`endif
      tick();
      check("reg_load", y8_q, 8'h3C);
      ld = 1'b0;
      s = 5'd0;
      d8[7:0] = 8'h11;
      tick();
      check("reg_hold", y8_q, 8'h3C);
      check("reg_hold_y", y8, 8'h11);

      // Asynchronous reset between edges.
      do_reset_now();
      #1;
      check("areset_y8_q", y8_q, 8'h00);
      check("areset_y8", y8, 8'h11);
      s = 5'd7;
      #1;
      check("areset_y8_track", y8, 8'h3C);
      rst_n = 1'b1;
      ld = 1'b1;
      tick();
      check("areset_reload", y8_q, 8'h3C);
      ld = 1'b0;

      // Select boundaries.
      d1 = 32'h0000_0001;
      d8 = {8'h00, {30{8'h00}}, 8'hFF};
      s = 5'd0;
      #1;
      check("bound_s0_w1", {7'b0, y1}, 8'h01);
      check("bound_s0_w8", y8, 8'hFF);
      d1 = 32'h7FFF_FFFF;
      d8 = {8'h00, {30{8'hFF}}, 8'hFF};
      s = 5'd31;
      #1;
      check("bound_s31_w1", {7'b0, y1}, 8'h00);
      check("bound_s31_w8", y8, 8'h00);
      tick();

`ifdef MUX32_VALID_EN
      // Valid gating: ld without in_valid leaves y_q and out_valid alone.
      do_reset_now();
      #1;
      rst_n = 1'b1;
      d8[5*8 +: 8] = 8'hA7;
      s = 5'd5;
      ld = 1'b1;
      in_valid = 1'b0;
      tick();
      check("valid_gate_yq", y8_q, 8'h00);
      check("valid_gate_ov", {7'b0, ov8}, 8'h00);
      in_valid = 1'b1;
      tick();
      check("valid_load_yq", y8_q, 8'hA7);
      check("valid_load_ov", {7'b0, ov8}, 8'h01);
`endif

      // Randomized traffic with occasional mid-cycle resets.
      for (int n = 0; n < 400; n++) begin
         d1 = $urandom;
         d8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         s = 5'($urandom_range(31, 0));
         ld = 1'($urandom_range(1, 0));
`ifdef MUX32_VALID_EN
         in_valid = 1'($urandom_range(3, 0) != 0);
`endif
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(29, 0) == 0) begin
            do_reset_now();
         end
         tick();
      end

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_32.md
Name: mux_32

Overview:
- 32-to-1 selector. Routes one of 32 data inputs to the output, chosen by a 5-bit unsigned select.
- Provides a combinational output `y` for datapath use and a registered copy `y_q` for timing-isolated consumers.
- Used as the generic wide selector in the MIPS datapath, for example register-file read ports and result selection.

Parameters:
- WIDTH, 1, bit width of each data input and of both outputs (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- d  input  32*WIDTH  packed data inputs; input k occupies bits [k*WIDTH +: WIDTH], k = 0..31.
- s  input  5  unsigned select, 0..31.
- ld  input  1  load enable for the output register.
- y  output  WIDTH  combinational selected data.
- y_q  output  WIDTH  registered selected data.

Behaviour:
- Combinational path:
  - `y` = input number `s` of `d`. All 32 select values are legal; there is no out-of-range case.
  - Zero latency. `y` changes within the same delta cycle as any change on `d` or `s`.
  - `y` does not depend on `clk`, `rst_n` or `ld`. It stays valid during reset.
- Unknown select: if any bit of `s` is X/Z, `y` is all X in simulation. Implement this with a case statement with a default X assignment; do not silently pick input 0.
- Registered path:
  - On rising `clk` with `ld` = 1, `y_q` takes the current value of `y`.
  - With `ld` = 0, `y_q` holds its value.
  - Latency from `d`/`s` to `y_q` is one cycle.
- Reset:
  - `rst_n` = 0 asynchronously forces `y_q` to all zeros, regardless of `clk` and `ld`.
  - Release is synchronous in effect: the first capture happens on the first rising edge after `rst_n` goes high with `ld` = 1.
  - Reset asserted mid-operation clears `y_q` immediately. `y` is unaffected.
- Simultaneous events: a change on `s` or `d` in the same cycle as `ld` = 1 is captured using the values present at the clock edge (standard setup rules).
- No other state. The block has no FSM and no handshake beyond `ld`.
- Width rules: all paths are exactly WIDTH bits, with no extension or truncation.

Optional Feature:
- Macro: MUX32_VALID_EN.
- When defined:
  - Adds input `in_valid` (1 bit) and output `out_valid` (1 bit).
  - `out_valid` is registered. On each rising edge it takes `in_valid & ld`, and it clears to 0 on reset.
  - `y_q` updates only when `in_valid & ld` = 1.
  - `y` is unchanged.
- When not defined:
  - These ports do not exist.
  - `y_q` updates whenever `ld` = 1.

Test Plan:
- Walking-one, WIDTH = 1: `d` = only bit k set, `s` = k, for k = 0..31 -> `y` = 1 each time. Then `s` = (k+1) mod 32 -> `y` = 0.
- Exhaustive select, WIDTH = 1: d = 32'hA5C3_0F96, sweep `s` = 0..31 -> `y` equals d bit s for every s; 32 checks, 0 errors.
- Registered path: WIDTH = 8, input 7 = 8'h3C, `s` = 7, `ld` = 1 for one edge -> `y_q` = 8'h3C one cycle later. Then `ld` = 0, `s` = 0 -> `y_q` holds 8'h3C while `y` shows input 0.
- Async reset: with `y_q` = 8'h3C, drive `rst_n` low between clock edges -> `y_q` = 8'h00 immediately while `y` still tracks `d`/`s`. Release with `ld` = 1 -> next edge reloads.
- Select boundaries: `s` = 5'd0 and `s` = 5'd31 with input 0 = 1, input 31 = 0 and all others opposite -> `y` = 1 then `y` = 0.
- With MUX32_VALID_EN: `ld` = 1, `in_valid` = 0 -> `y_q` and `out_valid` = 0 unchanged. `in_valid` = 1 -> next edge `out_valid` = 1 and `y_q` = selected data.
